// File: rtl/csr_access_unit.sv
// CSR instruction sequencer: decodes a Zicsr op, then performs the read,
// the read-modify-write and the rd response over a small four-state FSM.
module csr_access_unit #(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 pause_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           req_funct3_i,
    input  logic [11:0]          req_addr_i,
    input  logic [REG_WIDTH-1:0] req_rs1_data_i,
    input  logic [4:0]           req_uimm_i,
    input  logic                 req_rd_zero_i,
    output logic                 csr_read_ena_o,
    output logic [11:0]          csr_read_addr_o,
    input  logic [REG_WIDTH-1:0] csr_read_data_i,
    output logic                 csr_write_ena_o,
    output logic [11:0]          csr_write_addr_o,
    output logic [REG_WIDTH-1:0] csr_write_data_o,
    input  logic                 trap_enter_i,
    output logic                 rsp_valid_o,
    output logic [REG_WIDTH-1:0] rsp_rd_data_o,
    output logic                 rsp_illegal_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q;
    logic [11:0]            addr_q;
    logic [REG_WIDTH-1:0]   src_q;
    logic [REG_WIDTH-1:0]   old_q;
    logic                   do_write_q;
    logic                   illegal_q;

    // Decode is done on the live request but only consumed at the accept edge.
    logic accept;
    logic is_rw;
    logic do_write;
    logic do_read;
    logic illegal;

    assign accept   = (state_q == ST_IDLE) && req_valid_i && !pause_i;
    assign is_rw    = (req_funct3_i[1:0] == 2'b01);
    assign do_write = is_rw || (req_uimm_i != 5'd0);
    assign do_read  = !(is_rw && req_rd_zero_i);
    assign illegal  = (req_funct3_i[1:0] == 2'b00) ||
                      (do_write && (req_addr_i[11:10] == 2'b11));

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            op_q       <= 2'b00;
            addr_q     <= 12'h000;
            src_q      <= '0;
            old_q      <= '0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= req_funct3_i[1:0];
            addr_q     <= req_addr_i;
            src_q      <= req_funct3_i[2] ? {{(REG_WIDTH-5){1'b0}}, req_uimm_i} : req_rs1_data_i;
            old_q      <= '0;
            do_write_q <= do_write;
            illegal_q  <= illegal;
        end else if (state_q == ST_READ && !pause_i && !trap_enter_i) begin
            old_q <= csr_read_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal)      state_d = ST_RESP;
                    else if (do_read) state_d = ST_READ;
                    else              state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (trap_enter_i)  state_d = ST_IDLE;
                else if (!pause_i) state_d = do_write_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                if (trap_enter_i)  state_d = ST_IDLE;
                else if (!pause_i) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o      = (state_q == ST_IDLE);
        csr_read_ena_o   = 1'b0;
        csr_read_addr_o  = 12'h000;
        csr_write_ena_o  = 1'b0;
        csr_write_addr_o = 12'h000;
        csr_write_data_o = '0;
        rsp_valid_o      = 1'b0;
        rsp_rd_data_o    = '0;
        rsp_illegal_o    = 1'b0;
        dbg_state_o      = state_q;
        case (state_q)
            ST_READ: begin
                csr_read_ena_o  = 1'b1;
                csr_read_addr_o = addr_q;
            end
            ST_WRITE: begin
                csr_write_ena_o  = 1'b1;
                csr_write_addr_o = addr_q;
                case (op_q)
                    2'b10:   csr_write_data_o = old_q | src_q;
                    2'b11:   csr_write_data_o = old_q & ~src_q;
                    default: csr_write_data_o = src_q;
                endcase
            end
            ST_RESP: begin
                rsp_valid_o   = 1'b1;
                rsp_rd_data_o = old_q;
                rsp_illegal_o = illegal_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: each step drives inputs just after a
// rising edge, advances one clock and checks outputs 1ns after the next edge.
module tb_csr_access_unit;

    localparam int W = 64;

    logic          clk_sys_i = 1'b0;
    logic          rst_sys_i;
    logic          pause_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [2:0]    req_funct3_i;
    logic [11:0]   req_addr_i;
    logic [W-1:0]  req_rs1_data_i;
    logic [4:0]    req_uimm_i;
    logic          req_rd_zero_i;
    logic          csr_read_ena_o;
    logic [11:0]   csr_read_addr_o;
    logic [W-1:0]  csr_read_data_i;
    logic          csr_write_ena_o;
    logic [11:0]   csr_write_addr_o;
    logic [W-1:0]  csr_write_data_o;
    logic          trap_enter_i;
    logic          rsp_valid_o;
    logic [W-1:0]  rsp_rd_data_o;
    logic          rsp_illegal_o;
    logic [1:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    csr_access_unit #(.REG_WIDTH(W)) dut (
        .clk_sys_i        (clk_sys_i),
        .rst_sys_i        (rst_sys_i),
        .pause_i          (pause_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_funct3_i     (req_funct3_i),
        .req_addr_i       (req_addr_i),
        .req_rs1_data_i   (req_rs1_data_i),
        .req_uimm_i       (req_uimm_i),
        .req_rd_zero_i    (req_rd_zero_i),
        .csr_read_ena_o   (csr_read_ena_o),
        .csr_read_addr_o  (csr_read_addr_o),
        .csr_read_data_i  (csr_read_data_i),
        .csr_write_ena_o  (csr_write_ena_o),
        .csr_write_addr_o (csr_write_addr_o),
        .csr_write_data_o (csr_write_data_o),
        .trap_enter_i     (trap_enter_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rd_data_o    (rsp_rd_data_o),
        .rsp_illegal_o    (rsp_illegal_o),
        .dbg_state_o      (dbg_state_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [W-1:0] rs1,
                         input logic [4:0] uimm, input logic rdz);
        req_valid_i    = 1'b1;
        req_funct3_i   = f3;
        req_addr_i     = addr;
        req_rs1_data_i = rs1;
        req_uimm_i     = uimm;
        req_rd_zero_i  = rdz;
        tick();
        req_valid_i    = 1'b0;
    endtask

    // Outputs of an idle unit: ready only, everything else zero.
    task automatic check_idle(input string tag);
        check({tag, "_ready"}, W'(req_ready_o), W'(1));
        check({tag, "_rena"},  W'(csr_read_ena_o), W'(0));
        check({tag, "_raddr"}, W'(csr_read_addr_o), W'(0));
        check({tag, "_wena"},  W'(csr_write_ena_o), W'(0));
        check({tag, "_waddr"}, W'(csr_write_addr_o), W'(0));
        check({tag, "_wdata"}, csr_write_data_o, W'(0));
        check({tag, "_rsp"},   W'(rsp_valid_o), W'(0));
        check({tag, "_rd"},    rsp_rd_data_o, W'(0));
        check({tag, "_ill"},   W'(rsp_illegal_o), W'(0));
    endtask

    task automatic check_read(input string tag, input logic [11:0] addr);
        check({tag, "_rena"},  W'(csr_read_ena_o), W'(1));
        check({tag, "_raddr"}, W'(csr_read_addr_o), W'(addr));
        check({tag, "_wena"},  W'(csr_write_ena_o), W'(0));
        check({tag, "_ready"}, W'(req_ready_o), W'(0));
        check({tag, "_rsp"},   W'(rsp_valid_o), W'(0));
    endtask

    task automatic check_write(input string tag, input logic [11:0] addr, input logic [W-1:0] data);
        check({tag, "_wena"},  W'(csr_write_ena_o), W'(1));
        check({tag, "_waddr"}, W'(csr_write_addr_o), W'(addr));
        check({tag, "_wdata"}, csr_write_data_o, data);
        check({tag, "_rena"},  W'(csr_read_ena_o), W'(0));
        check({tag, "_rsp"},   W'(rsp_valid_o), W'(0));
    endtask

    task automatic check_rsp(input string tag, input logic [W-1:0] rd, input logic ill);
        check({tag, "_rsp"},  W'(rsp_valid_o), W'(1));
        check({tag, "_rd"},   rsp_rd_data_o, rd);
        check({tag, "_ill"},  W'(rsp_illegal_o), W'(ill));
        check({tag, "_rena"}, W'(csr_read_ena_o), W'(0));
        check({tag, "_wena"}, W'(csr_write_ena_o), W'(0));
    endtask

    initial begin
        rst_sys_i       = 1'b1;
        pause_i         = 1'b0;
        req_valid_i     = 1'b0;
        req_funct3_i    = 3'b000;
        req_addr_i      = 12'h000;
        req_rs1_data_i  = '0;
        req_uimm_i      = 5'd0;
        req_rd_zero_i   = 1'b0;
        csr_read_data_i = '0;
        trap_enter_i    = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst_sys_i = 1'b0;
        tick();

        // CSRRS 0x300, rs1=0x8, CSR=0x80
        csr_read_data_i = 64'h80;
        issue(3'b010, 12'h300, 64'h8, 5'd5, 1'b0);
        check_read("rs_read", 12'h300);
        tick();
        check_write("rs_write", 12'h300, 64'h88);
        tick();
        check_rsp("rs_rsp", 64'h80, 1'b0);
        tick();
        check_idle("rs_idle");

        // CSRRW 0x305 rd=x0, write only
        issue(3'b001, 12'h305, 64'h1000, 5'd3, 1'b1);
        check_write("rw_write", 12'h305, 64'h1000);
        tick();
        check_rsp("rw_rsp", 64'h0, 1'b0);
        tick();
        check_idle("rw_idle");

        // CSRRCI uimm=0 on 0x341 holding 0x40: read only
        csr_read_data_i = 64'h40;
        issue(3'b111, 12'h341, 64'hFFFF, 5'd0, 1'b0);
        check_read("rci_read", 12'h341);
        tick();
        check_rsp("rci_rsp", 64'h40, 1'b0);
        tick();
        check_idle("rci_idle");

        // CSRRC 0x340 rs1=0x0F on 0xFF -> write 0xF0
        csr_read_data_i = 64'hFF;
        issue(3'b011, 12'h340, 64'h0F, 5'd2, 1'b0);
        check_read("rc_read", 12'h340);
        tick();
        check_write("rc_write", 12'h340, 64'hF0);
        tick();
        check_rsp("rc_rsp", 64'hFF, 1'b0);
        tick();

        // CSRRSI uimm=0x11 on 0x100 -> write 0x111
        csr_read_data_i = 64'h100;
        issue(3'b110, 12'h304, 64'hDEAD, 5'h11, 1'b0);
        check_read("rsi_read", 12'h304);
        tick();
        check_write("rsi_write", 12'h304, 64'h111);
        tick();
        check_rsp("rsi_rsp", 64'h100, 1'b0);
        tick();

        // CSRRW to read-only 0xF14 is illegal, then funct3=100
        issue(3'b001, 12'hF14, 64'h1234, 5'd1, 1'b0);
        check_rsp("ill_ro_rsp", 64'h0, 1'b1);
        tick();
        check_idle("ill_ro_idle");
        issue(3'b100, 12'h300, 64'h1234, 5'd1, 1'b0);
        check_rsp("ill_f3_rsp", 64'h0, 1'b1);
        tick();
        check_idle("ill_f3_idle");

        // Request during pause is not accepted
        pause_i     = 1'b1;
        req_valid_i = 1'b1;
        req_funct3_i = 3'b001;
        req_addr_i  = 12'h305;
        tick();
        check_idle("pause_idle");
        req_valid_i = 1'b0;
        pause_i     = 1'b0;

        // Pause held 3 cycles in WRITE: write_ena for 4 cycles, constant data
        issue(3'b001, 12'h305, 64'h55, 5'd7, 1'b1);
        check_write("pw_c1", 12'h305, 64'h55);
        pause_i = 1'b1;
        tick();
        check_write("pw_c2", 12'h305, 64'h55);
        tick();
        check_write("pw_c3", 12'h305, 64'h55);
        tick();
        check_write("pw_c4", 12'h305, 64'h55);
        pause_i = 1'b0;
        tick();
        check_rsp("pw_rsp", 64'h0, 1'b0);
        tick();
        check_idle("pw_idle");

        // Pause in RESP does not hold the response
        csr_read_data_i = 64'h7;
        issue(3'b111, 12'h341, 64'h0, 5'd0, 1'b0);
        tick();
        check_rsp("prsp_rsp", 64'h7, 1'b0);
        pause_i = 1'b1;
        tick();
        check_idle("prsp_idle");
        pause_i = 1'b0;

        // Trap in READ: back to IDLE, no response
        csr_read_data_i = 64'h80;
        issue(3'b010, 12'h300, 64'h8, 5'd1, 1'b0);
        check_read("trap_read", 12'h300);
        trap_enter_i = 1'b1;
        tick();
        trap_enter_i = 1'b0;
        check_idle("trap_idle1");
        tick();
        check_idle("trap_idle2");

        // Reset in WRITE: all outputs at reset values next cycle
        issue(3'b001, 12'h305, 64'hABCD, 5'd4, 1'b1);
        check_write("rst_write", 12'h305, 64'hABCD);
        rst_sys_i = 1'b1;
        pause_i   = 1'b1;
        tick();
        check_idle("rst_idle");
        rst_sys_i = 1'b0;
        pause_i   = 1'b0;
        tick();
        check_idle("rst_idle2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
